h14tx_di_packer: RTL



---
 rtl/h14tx_pkg.sv | 40 ++++
 rtl/h14tx_bch_ecc.sv | 43 ++++
 rtl/h14tx_di_packer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/h14tx_pkg.sv
`default_nettype none
// ============================================================================
// Module : h14tx_pkg
// Brief  : Shared types and constants for the HDMI 1.4 TX data-island path:
//          period encoding, packet geometry, BCH polynomial and step helper.
// Rev    : 1.0  initial release
// ============================================================================
package h14tx_pkg;

    // Period classification produced by the data-period timing decoder
    typedef enum logic [2:0] {
        Control            = 3'd0,
        VideoPreamble      = 3'd1,
        VideoGuard         = 3'd2,
        VideoActive        = 3'd3,
        DataIslandPreamble = 3'd4,
        DataIslandGuard    = 3'd5,
        DataIslandActive   = 3'd6
    } period_t;

    localparam int         PacketClocks  = 32;
    localparam int         HeaderBits    = 24;
    localparam int         SubpacketBits = 56;
    localparam int         Subpackets    = 4;
    localparam logic [7:0] BchPoly       = 8'h83;

    typedef struct packed {
        logic [HeaderBits-1:0]              header;
        logic [Subpackets*SubpacketBits-1:0] body;
    } di_packet_t;

    // One serial BCH step: feedback is the input bit xor the register LSB
    function automatic logic [7:0] bch_step(input logic [7:0] ecc, input logic bit_in);
        logic fb;
        fb = bit_in ^ ecc[0];
        return (ecc >> 1) ^ (fb ? BchPoly : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/h14tx_bch_ecc.sv
`default_nettype none
// ============================================================================
// Module : h14tx_bch_ecc
// Brief  : Serial BCH ECC accumulator, BITS input bits per clock (bit 0 first).
//          clear restarts the accumulation from zero in the same cycle.
// Rev    : 1.0  initial release
// ============================================================================
module h14tx_bch_ecc
    import h14tx_pkg::*;
#(
    parameter int BITS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            enable,
    input  logic [BITS-1:0] din,
    output logic [7:0]      ecc
);

    logic [7:0] w_next;

    // Fold the incoming bits into the register, starting from zero on clear
    always_comb begin
        w_next = clear ? 8'h00 : ecc;
        for (int i = 0; i < BITS; i++) begin
            w_next = bch_step(w_next, din[i]);
        end
    end

    // ECC register: accumulates while enabled, then holds for transmission
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ecc <= 8'h00;
        end else if (enable) begin
            ecc <= w_next;
        end else if (clear) begin
            ecc <= 8'h00;
        end
    end

endmodule
`default_nettype wire

// File: rtl/h14tx_di_packer.sv
`default_nettype none
// ============================================================================
// Module : h14tx_di_packer
// Brief  : Buffers one data-island packet and serialises it into per-clock
//          TERC4 source nibbles for channels 0..2 during each 32-clock slot,
//          appending serially computed BCH ECC.
// Rev    : 1.0  initial release
// ============================================================================
module h14tx_di_packer
    import h14tx_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst_n,
    input  period_t                             timings,
    input  logic                                hsync,
    input  logic                                vsync,
    input  logic                                pkt_valid,
    output logic                                pkt_ready,
    input  logic [HeaderBits-1:0]               pkt_header,
    input  logic [Subpackets*SubpacketBits-1:0] pkt_body,
    output period_t                             timings_o,
    output logic [3:0]                          di_ch0,
    output logic [3:0]                          di_ch1,
    output logic [3:0]                          di_ch2,
    output logic                                di_abort
);

    localparam logic [4:0] HDR_CLOCKS  = 5'(HeaderBits);
    localparam logic [4:0] BODY_CLOCKS = 5'(SubpacketBits / 2);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                                r_state, w_state_next;
    logic [4:0]                            r_cnt, w_cnt_next;
    logic                                  w_active, w_slot_load, w_abort_next, w_accept;
    logic                                  r_ready_en, r_full;
    di_packet_t                            r_buf, w_src;
    logic [HeaderBits-1:0]                 r_hdr_sh, w_hdr_cur;
    logic [Subpackets-1:0][SubpacketBits-1:0] r_sub_sh, w_sub_cur;
    logic [7:0]                            w_hdr_ecc;
    logic [Subpackets-1:0][7:0]            w_sub_ecc;
    logic                                  w_hdr_en, w_sub_en, w_hdr_out;
    logic [3:0]                            w_ch1, w_ch2;

    assign w_active    = (timings == DataIslandActive);
    // r_cnt is the slot clock index of the current cycle (0 in IDLE)
    assign w_slot_load = w_active && (r_cnt == 5'd0);
    // The buffer frees up in the very cycle its packet moves to the shifters
    assign pkt_ready   = r_ready_en && (!r_full || w_slot_load);
    assign w_accept    = pkt_valid && pkt_ready;
    assign w_src       = r_full ? r_buf : '0;
    assign w_hdr_cur   = w_slot_load ? w_src.header : r_hdr_sh;
    assign w_hdr_en    = w_active && (r_cnt < HDR_CLOCKS);
    assign w_sub_en    = w_active && (r_cnt < BODY_CLOCKS);

    h14tx_bch_ecc #(.BITS(1)) u_hdr_ecc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_slot_load),
        .enable (w_hdr_en),
        .din    (w_hdr_cur[0]),
        .ecc    (w_hdr_ecc)
    );

    generate
        for (genvar k = 0; k < Subpackets; k++) begin : g_sub
            assign w_sub_cur[k] = w_slot_load ? w_src.body[k*SubpacketBits +: SubpacketBits]
                                              : r_sub_sh[k];
            h14tx_bch_ecc #(.BITS(2)) u_sub_ecc (
                .clk    (clk),
                .rst_n  (rst_n),
                .clear  (w_slot_load),
                .enable (w_sub_en),
                .din    (w_sub_cur[k][1:0]),
                .ecc    (w_sub_ecc[k])
            );
        end
    endgenerate

    // Slot sequencing: leaving Active before the last slot clock is an abort
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_abort_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_active) begin
                    w_state_next = SEND;
                    w_cnt_next   = 5'd1;
                end
            end
            SEND: begin
                if (w_active) begin
                    w_cnt_next = r_cnt + 5'd1;
                end else begin
                    w_state_next = IDLE;
                    w_cnt_next   = 5'd0;
                    w_abort_next = (r_cnt != 5'd0);
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = 5'd0;
            end
        endcase
    end

    // State and slot counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 5'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Single-entry holding buffer; an accept in a load cycle refills it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready_en <= 1'b0;
            r_full     <= 1'b0;
            r_buf      <= '0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_slot_load) begin
                r_full <= 1'b0;
            end
            if (w_accept) begin
                r_full       <= 1'b1;
                r_buf.header <= pkt_header;
                r_buf.body   <= pkt_body;
            end
        end
    end

    // Payload shifters: header one bit per clock, subpackets two bits per clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hdr_sh <= '0;
            r_sub_sh <= '0;
        end else if (w_active) begin
            r_hdr_sh <= w_hdr_cur >> 1;
            for (int k = 0; k < Subpackets; k++) begin
                r_sub_sh[k] <= w_sub_cur[k] >> 2;
            end
        end
    end

    // Select payload or ECC bits for the current slot clock (ECC sent LSB first)
    always_comb begin
        w_ch1     = '0;
        w_ch2     = '0;
        w_hdr_out = (r_cnt < HDR_CLOCKS) ? w_hdr_cur[0] : w_hdr_ecc[r_cnt[2:0]];
        for (int k = 0; k < Subpackets; k++) begin
            w_ch1[k] = (r_cnt < BODY_CLOCKS) ? w_sub_cur[k][0]
                                             : w_sub_ecc[k][{r_cnt[1:0], 1'b0}];
            w_ch2[k] = (r_cnt < BODY_CLOCKS) ? w_sub_cur[k][1]
                                             : w_sub_ecc[k][{r_cnt[1:0], 1'b1}];
        end
    end

    // Output registers, one cycle behind the timing input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timings_o <= Control;
            di_ch0    <= 4'h0;
            di_ch1    <= 4'h0;
            di_ch2    <= 4'h0;
            di_abort  <= 1'b0;
        end else begin
            timings_o <= timings;
            di_abort  <= w_abort_next;
            if (w_active) begin
                di_ch0 <= {(r_cnt != 5'd0), w_hdr_out, vsync, hsync};
                di_ch1 <= w_ch1;
                di_ch2 <= w_ch2;
            end else begin
                di_ch0 <= {2'b10, vsync, hsync};
                di_ch1 <= 4'h0;
                di_ch2 <= 4'h0;
            end
        end
    end

endmodule
`default_nettype wire
